// File: rtl/decoder_scan_ctrl_if.sv
// decoder_scan_ctrl_if
//   Bundles the control and decoder-drive signals of decoder_scan_ctrl.
//   master: the issuing controller (drives start/stop/config, observes status).
//   slave : decoder_scan_ctrl itself.
//   Signals:
//     start, stop              1-cycle request pulses from the controller
//     first_addr, last_addr    scan range (ADDR_W)
//     dwell                    extra hold cycles per address (DWELL_W)
//     continuous               1 = repeat the range until stop
//     dec_en, dec_a            drive for the downstream 6-to-64 decoder
//     busy, done, wrap         scan status back to the controller
interface decoder_scan_ctrl_if #(
  parameter int ADDR_W  = 6,
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  first_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic [DWELL_W-1:0] dwell;
  logic               continuous;
  logic               dec_en;
  logic [ADDR_W-1:0]  dec_a;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, first_addr, last_addr, dwell, continuous,
    input  dec_en, dec_a, busy, done, wrap
  );

  modport slave (
    input  start, stop, first_addr, last_addr, dwell, continuous,
    output dec_en, dec_a, busy, done, wrap
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Sweeps a decoder select over [first_addr..last_addr] (up or down), holding
//   each address for dwell+1 cycles, in single-pass or continuous mode.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous, active-high reset
//     ctrl_if  decoder_scan_ctrl_if.slave (start/stop/config in, dec/status out)
//     state_o  current FSM state, for debug and checkers
//   Optional build macro: DECODER_SCAN_GAP_EN -- adds a one-cycle GAP state with
//     dec_en low between consecutive addresses (break-before-make).
//
//   Handshake: there is no ready. start is a 1-cycle pulse taken only in IDLE
//   with stop low; start+config are latched on that edge and busy rises on the
//   next cycle. stop is a 1-cycle pulse honoured in every non-IDLE state and
//   wins over start in IDLE. All outputs are registered.
module decoder_scan_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  decoder_scan_ctrl_if.slave  ctrl_if,
  output logic [1:0]          state_o
);

`ifdef DECODER_SCAN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               up;

  // Direction is implied by the latched range ends.
  assign up = (first_q <= last_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_if.start && !ctrl_if.stop) begin
          first_d = ctrl_if.first_addr;
          last_d  = ctrl_if.last_addr;
          dwell_d = ctrl_if.dwell;
          cont_d  = ctrl_if.continuous;
          addr_d  = ctrl_if.first_addr;
          cnt_d   = ctrl_if.dwell;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (ctrl_if.stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          en_d   = 1'b1;
          busy_d = 1'b1;
        end else if (addr_q == last_q) begin
          if (cont_q) begin
            // Range reload: the only way the address ever jumps.
            addr_d = first_q;
            cnt_d  = dwell_q;
            busy_d = 1'b1;
            wrap_d = 1'b1;
`ifdef DECODER_SCAN_GAP_EN
            state_d = GAP;
`else
            en_d    = 1'b1;
`endif
          end else begin
            // dec_a keeps the last address through DONE and IDLE.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          addr_d = up ? addr_q + 1'b1 : addr_q - 1'b1;
          cnt_d  = dwell_q;
          busy_d = 1'b1;
`ifdef DECODER_SCAN_GAP_EN
          state_d = GAP;
`else
          en_d    = 1'b1;
`endif
        end
      end
`ifdef DECODER_SCAN_GAP_EN
      GAP: begin
        // Address already moved; the dwell count was reloaded on entry.
        if (ctrl_if.stop) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ctrl_if.dec_en = en_q;
  assign ctrl_if.dec_a  = addr_q;
  assign ctrl_if.busy   = busy_q;
  assign ctrl_if.done   = done_q;
  assign ctrl_if.wrap   = wrap_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl
//   Directed + randomised bench for decoder_scan_ctrl. Expected output words
//   {dec_en, dec_a, busy, done, wrap} are generated from the scan description
//   and queued when stimulus is set up, then popped one per clock.
module tb_decoder_scan_ctrl;
  localparam int W = 10;

  logic clk;
  logic rst;
  logic [1:0]  state_dbg;
  logic [63:0] dec_y;

  decoder_scan_ctrl_if #(.ADDR_W(6), .DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.ADDR_W(6), .DWELL_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus),
    .state_o (state_dbg)
  );

  // Behavioural stand-in for the downstream decoder_6x64.
  assign dec_y = bus.dec_en ? (64'd1 << bus.dec_a) : 64'd0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic push_cycle(input logic en, input logic [5:0] a,
                            input logic busy, input logic done, input logic wrap);
    exp_q.push_back({en, a, busy, done, wrap});
  endtask

  task automatic push_idle(input logic [5:0] a, input int n);
    for (int i = 0; i < n; i++) push_cycle(1'b0, a, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected trace for `passes` full passes over the range, plus the done
  // cycle when not continuous.
  task automatic push_scan(input int first, input int last, input int dwell,
                           input bit cont, input int passes);
    int n;
    logic [5:0] a;
    logic w;
    n = (first <= last) ? (last - first + 1) : (first - last + 1);
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n; k++) begin
        a = (first <= last) ? 6'(first + k) : 6'(first - k);
        w = (p > 0) && (k == 0);
`ifdef DECODER_SCAN_GAP_EN
        if (p > 0 || k > 0) begin
          push_cycle(1'b0, a, 1'b1, 1'b0, w);
          w = 1'b0;
        end
`endif
        for (int d = 0; d <= dwell; d++) push_cycle(1'b1, a, 1'b1, 1'b0, w && (d == 0));
      end
    end
    if (!cont) push_cycle(1'b0, 6'(last), 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic [5:0] f, input logic [5:0] l,
                         input logic [7:0] d, input logic c);
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.dwell      = d;
    bus.continuous = c;
  endtask

  // Advance one clock, drop the request pulses, compare against the queue head.
  task automatic step(input string tag, input int idx);
    logic [W-1:0] exp_w, obs_w;
    logic [63:0]  y_exp;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    exp_w = exp_q.pop_front();
    obs_w = {bus.dec_en, bus.dec_a, bus.busy, bus.done, bus.wrap};
    n_cmp++;
    assert (obs_w === exp_w) else begin
      n_fail++;
      $error("FAIL %s[%0d] outputs{en,a,busy,done,wrap} obs=%0b_%0d_%0b%0b%0b exp=%0b_%0d_%0b%0b%0b",
             tag, idx, obs_w[9], obs_w[8:3], obs_w[2], obs_w[1], obs_w[0],
             exp_w[9], exp_w[8:3], exp_w[2], exp_w[1], exp_w[0]);
    end
    y_exp = exp_w[9] ? (64'd1 << exp_w[8:3]) : 64'd0;
    n_cmp++;
    assert (dec_y === y_exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] decoder_y obs=%h exp=%h", tag, idx, dec_y, y_exp);
    end
  endtask

  task automatic run_queue(input string tag);
    int i = 0;
    while (exp_q.size() > 0) begin
      step(tag, i);
      i++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int i;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(6'd3, 6'd9, 8'd1, 1'b0);

    // 1. reset for 3 cycles with start held: outputs stay zero
    for (int k = 0; k < 3; k++) begin
      bus.start = 1'b1;
      push_idle(6'd0, 1);
      step("reset", k);
    end
    rst = 1'b0;
    push_idle(6'd0, 2);
    run_queue("post_reset");

    // 2. full upward sweep, 1 cycle per address
    set_cfg(6'd0, 6'd63, 8'd0, 1'b0);
    bus.start = 1'b1;
    push_scan(0, 63, 0, 1'b0, 1);
    push_idle(6'd63, 2);
    run_queue("sweep_0_63");

    // 3. downward sweep with dwell
    set_cfg(6'd10, 6'd7, 8'd2, 1'b0);
    bus.start = 1'b1;
    push_scan(10, 7, 2, 1'b0, 1);
    push_idle(6'd7, 1);
    run_queue("down_10_7");

    // 4. continuous 5..6, two passes, then stop mid-hold on the third pass
    set_cfg(6'd5, 6'd6, 8'd1, 1'b1);
    bus.start = 1'b1;
    push_scan(5, 6, 1, 1'b1, 2);
`ifdef DECODER_SCAN_GAP_EN
    push_cycle(1'b0, 6'd5, 1'b1, 1'b0, 1'b1);
    push_cycle(1'b1, 6'd5, 1'b1, 1'b0, 1'b0);
`else
    push_cycle(1'b1, 6'd5, 1'b1, 1'b0, 1'b1);
`endif
    run_queue("cont_5_6");
    bus.stop = 1'b1;
    push_idle(6'd5, 3);
    run_queue("cont_stop");

    // 5. single address, max dwell; a start mid-scan must be ignored
    set_cfg(6'd42, 6'd42, 8'd255, 1'b0);
    bus.start = 1'b1;
    push_scan(42, 42, 255, 1'b0, 1);
    push_idle(6'd42, 1);
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 100) begin
        bus.start = 1'b1;
        set_cfg(6'd0, 6'd1, 8'd0, 1'b1);
      end
      step("single_42", i);
      i++;
    end
    // start and stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    push_idle(6'd42, 3);
    run_queue("start_stop_idle");

    // 6. short range showing address steps (GAP cycles when compiled in)
    set_cfg(6'd0, 6'd2, 8'd0, 1'b0);
    bus.start = 1'b1;
    push_scan(0, 2, 0, 1'b0, 1);
    push_idle(6'd2, 1);
    run_queue("short_0_2");

    // 7. randomised single-pass scans
    for (int r = 0; r < 4; r++) begin
      int f, l, d;
      f = $urandom_range(0, 63);
      l = $urandom_range(0, 63);
      if (f > l + 8) l = f - 8;
      if (l > f + 8) l = f + 8;
      d = $urandom_range(0, 3);
      set_cfg(6'(f), 6'(l), 8'(d), 1'b0);
      bus.start = 1'b1;
      push_scan(f, l, d, 1'b0, 1);
      push_idle(6'(l), 1);
      run_queue($sformatf("rand%0d_%0d_%0d_%0d", r, f, l, d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
